// File: rtl/reg_bank_responder.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_responder
// Description : Request/response register bank with configurable response
//               latency, valid/ready on both channels and range-error flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_responder #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RESP_LAT   = 1,
    parameter int RESET_DATA = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int                 c_entries    = 1 << ADDR_W;
    localparam int                 c_cnt_w      = (RESP_LAT > 0) ? $clog2(RESP_LAT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_lat_load   = c_cnt_w'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);
    localparam logic [DATA_W-1:0]  c_reset_data = DATA_W'(RESET_DATA);
    localparam logic [ADDR_W:0]    c_depth      = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_resp_valid;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               r_resp_err;
    logic [DATA_W-1:0]  r_mem [0:c_entries-1];

    logic w_in_range;
    logic w_accept;

    assign w_in_range = ({1'b0, req_addr} < c_depth);
    // Ready depends only on state and resp_ready so a new request can ride the
    // same edge as the outgoing response handshake.
    assign req_ready  = (r_state == c_st_idle) || ((r_state == c_st_resp) && resp_ready);
    assign w_accept   = req_valid && req_ready;

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            for (int i = 0; i < c_entries; i++) begin
                r_mem[i] <= c_reset_data;
            end
        end else if (w_accept) begin
            if (req_write && w_in_range) begin
                r_mem[req_addr] <= req_wdata;
            end
            r_resp_rdata <= (!req_write && w_in_range) ? r_mem[req_addr] : '0;
            r_resp_err   <= !w_in_range;
            if (RESP_LAT > 0) begin
                r_state      <= c_st_wait;
                r_cnt        <= c_lat_load;
                r_resp_valid <= 1'b0;
            end else begin
                r_state      <= c_st_resp;
                r_resp_valid <= 1'b1;
            end
        end else begin
            case (r_state)
                c_st_wait: begin
                    if (r_cnt == '0) begin
                        r_state      <= c_st_resp;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_resp: begin
                    if (resp_ready) begin
                        r_state      <= c_st_idle;
                        r_resp_valid <= 1'b0;
                    end
                end
                c_st_idle: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state      <= c_st_idle;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_responder
// Description : Directed bench; dut_a uses defaults, dut_b uses DEPTH=12 and
//               zero response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_responder;

    logic       clock = 1'b0;
    logic       reset;
    logic       a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err;
    logic [3:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic       b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
    logic [3:0] b_req_addr, b_req_wdata, b_resp_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    reg_bank_responder dut_a (
        .clock(clock), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    reg_bank_responder #(.DEPTH(12), .RESP_LAT(0)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete transaction on dut_a; lat = edges from accept to resp_valid, 99 on timeout.
    task automatic a_txn(input logic wr, input logic [3:0] addr, input logic [3:0] wdata,
                         output logic [3:0] rdata, output logic err, output int lat);
        logic rdy;
        int   n;
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata;
        a_resp_ready = 1'b1;
        n = 0;
        do begin rdy = a_req_ready; step(); n++; end while (!rdy && n < 10);
        a_req_valid = 1'b0;
        lat = 0;
        while (!a_resp_valid && lat < 10) begin step(); lat++; end
        rdata = a_resp_rdata; err = a_resp_err;
        if (!rdy || !a_resp_valid) lat = 99;
        step();
    endtask

    task automatic b_txn(input logic wr, input logic [3:0] addr, input logic [3:0] wdata,
                         output logic [3:0] rdata, output logic err, output int lat);
        logic rdy;
        int   n;
        b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata;
        b_resp_ready = 1'b1;
        n = 0;
        do begin rdy = b_req_ready; step(); n++; end while (!rdy && n < 10);
        b_req_valid = 1'b0;
        lat = 0;
        while (!b_resp_valid && lat < 10) begin step(); lat++; end
        rdata = b_resp_rdata; err = b_resp_err;
        if (!rdy || !b_resp_valid) lat = 99;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        step();
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_a_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_a_resp_valid got=%b exp=0", a_resp_valid); end
        checks++; if (a_resp_rdata !== 4'h0) begin failures++; $display("FAIL reset_a_resp_rdata got=%h exp=0", a_resp_rdata); end
        checks++; if (a_resp_err !== 1'b0) begin failures++; $display("FAIL reset_a_resp_err got=%b exp=0", a_resp_err); end
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL reset_b_req_ready got=%b exp=1", b_req_ready); end
        checks++; if (b_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_b_resp_valid got=%b exp=0", b_resp_valid); end
    endtask

    task automatic test_read_default();
        logic [3:0] rd; logic er; int lat;
        a_txn(1'b0, 4'd3, 4'h0, rd, er, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL t1_latency got=%0d exp=1", lat); end
        checks++; if (rd !== 4'h5) begin failures++; $display("FAIL t1_rdata got=%h exp=5", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL t1_err got=%b exp=0", er); end
    endtask

    task automatic test_write_read();
        logic [3:0] rd; logic er; int lat;
        a_txn(1'b1, 4'd2, 4'hA, rd, er, lat);
        checks++; if (rd !== 4'h0) begin failures++; $display("FAIL t2_wr_rdata got=%h exp=0", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL t2_wr_err got=%b exp=0", er); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL t2_wr_latency got=%0d exp=1", lat); end
        a_txn(1'b0, 4'd2, 4'h0, rd, er, lat);
        checks++; if (rd !== 4'hA) begin failures++; $display("FAIL t2_rd2 got=%h exp=a", rd); end
        a_txn(1'b0, 4'd3, 4'h0, rd, er, lat);
        checks++; if (rd !== 4'h5) begin failures++; $display("FAIL t2_rd3 got=%h exp=5", rd); end
    endtask

    task automatic test_out_of_range();
        logic [3:0] rd; logic er; int lat;
        b_txn(1'b1, 4'd13, 4'h7, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL t3_wr13_err got=%b exp=1", er); end
        checks++; if (rd !== 4'h0) begin failures++; $display("FAIL t3_wr13_rdata got=%h exp=0", rd); end
        checks++; if (lat !== 0) begin failures++; $display("FAIL t3_latency got=%0d exp=0", lat); end
        b_txn(1'b0, 4'd13, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL t3_rd13_err got=%b exp=1", er); end
        checks++; if (rd !== 4'h0) begin failures++; $display("FAIL t3_rd13_rdata got=%h exp=0", rd); end
        b_txn(1'b0, 4'd12, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL t3_rd12_err got=%b exp=1", er); end
        b_txn(1'b0, 4'd11, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL t3_rd11_err got=%b exp=0", er); end
        checks++; if (rd !== 4'h5) begin failures++; $display("FAIL t3_rd11_rdata got=%h exp=5", rd); end
    endtask

    task automatic test_backpressure();
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 4'd2; a_resp_ready = 1'b0;
        step();
        a_req_valid = 1'b0;
        step();
        checks++; if (a_resp_valid !== 1'b1) begin failures++; $display("FAIL t4_resp_valid got=%b exp=1", a_resp_valid); end
        // Offer a second request while stalled; it must not be taken.
        a_req_valid = 1'b1; a_req_addr = 4'd3;
        for (int i = 0; i < 5; i++) begin
            checks++; if (a_resp_valid !== 1'b1) begin failures++; $display("FAIL t4_stall_valid cyc=%0d got=%b exp=1", i, a_resp_valid); end
            checks++; if (a_resp_rdata !== 4'hA) begin failures++; $display("FAIL t4_stall_rdata cyc=%0d got=%h exp=a", i, a_resp_rdata); end
            checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL t4_stall_req_ready cyc=%0d got=%b exp=0", i, a_req_ready); end
            step();
        end
        a_resp_ready = 1'b1;
        #1;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL t4_b2b_req_ready got=%b exp=1", a_req_ready); end
        step();
        a_req_valid = 1'b0;
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL t4_after_hs_valid got=%b exp=0", a_resp_valid); end
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL t4_wait_req_ready got=%b exp=0", a_req_ready); end
        step();
        checks++; if (a_resp_valid !== 1'b1) begin failures++; $display("FAIL t4_second_valid got=%b exp=1", a_resp_valid); end
        checks++; if (a_resp_rdata !== 4'h5) begin failures++; $display("FAIL t4_second_rdata got=%h exp=5", a_resp_rdata); end
        step();
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL t4_final_valid got=%b exp=0", a_resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rd; logic er; int lat;
        for (int i = 0; i < 8; i++) begin
            b_txn(1'b1, 4'(i), 4'(15 - i), rd, er, lat);
        end
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 4'd0; b_resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL t5_req_ready cyc=%0d got=%b exp=1", i, b_req_ready); end
            step();
            b_req_addr = 4'(i + 1);
            checks++; if (b_resp_valid !== 1'b1) begin failures++; $display("FAIL t5_valid cyc=%0d got=%b exp=1", i, b_resp_valid); end
            checks++; if (b_resp_rdata !== 4'(15 - i)) begin failures++; $display("FAIL t5_rdata cyc=%0d got=%h exp=%h", i, b_resp_rdata, 4'(15 - i)); end
        end
        b_req_valid = 1'b0;
        step();
        checks++; if (b_resp_valid !== 1'b0) begin failures++; $display("FAIL t5_drain_valid got=%b exp=0", b_resp_valid); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] rd; logic er; int lat;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 4'd1; a_req_wdata = 4'h3; a_resp_ready = 1'b1;
        step();
        a_req_valid = 1'b0;
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL t6_wait_valid got=%b exp=0", a_resp_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL t6_no_resp cyc=%0d got=%b exp=0", i, a_resp_valid); end
            step();
        end
        a_txn(1'b0, 4'd1, 4'h0, rd, er, lat);
        checks++; if (rd !== 4'h5) begin failures++; $display("FAIL t6_rd1 got=%h exp=5", rd); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL t6_latency got=%0d exp=1", lat); end
    endtask

    initial begin
        reset = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b0;
        test_reset();
        test_read_default();
        test_write_read();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
